// File: rtl/pacman_pkg.sv
// Shared types and constants for the Pac-Man motion controller and its renderer interface.
package pacman_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MOVING  = 2'd1,
    ST_STOPPED = 2'd2
  } state_t;

  localparam int EDGE_LEFT   = 3;
  localparam int EDGE_TOP    = 2;
  localparam int EDGE_RIGHT  = 1;
  localparam int EDGE_BOTTOM = 0;

  localparam int OBJECT_W = 32;
  localparam int OBJECT_H = 32;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  // Hit-edge bit that blocks motion in the given direction.
  function automatic logic [1:0] edge_idx(input dir_t d);
    logic [1:0] idx;
    unique case (d)
      UP:      idx = 2'(EDGE_TOP);
      DOWN:    idx = 2'(EDGE_BOTTOM);
      LEFT:    idx = 2'(EDGE_LEFT);
      default: idx = 2'(EDGE_RIGHT);
    endcase
    return idx;
  endfunction

  function automatic dir_t opposite(input dir_t d);
    dir_t o;
    unique case (d)
      UP:      o = DOWN;
      DOWN:    o = UP;
      LEFT:    o = RIGHT;
      default: o = LEFT;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/pacman_move_ctrl_hit_edge_accumulator.sv
// Per-frame OR-latch of renderer hit edges; frameHits holds the previous frame's edges
// while startOfFrame reloads the latch with the current cycle's code.
module hit_edge_accumulator
  import pacman_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       collision,
  input  logic [3:0] HitEdgeCode,
  output logic [3:0] frameHits
);

  always_ff @(posedge clk) begin
    if (reset) begin
      frameHits <= 4'b0000;
    end else if (startOfFrame) begin
      frameHits <= collision ? HitEdgeCode : 4'b0000;
    end else if (collision) begin
      frameHits <= frameHits | HitEdgeCode;
    end
  end

endmodule

// File: rtl/pacman_move_ctrl.sv
// Frame-rate Pac-Man motion controller: buffered turns, wall pull-back, screen range limits.
// PACMAN_TUNNEL_WRAP_EN: horizontal tunnel wrap instead of clamping X at the screen edges.
module pacman_move_ctrl
  import pacman_pkg::*;
#(
  parameter int INITIAL_X      = 288,
  parameter int INITIAL_Y      = 224,
  parameter int SPEED          = 2,
  parameter int PENDING_FRAMES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        keyValid,
  input  logic [1:0]  keyDir,
  input  logic        collision,
  input  logic [3:0]  HitEdgeCode,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY,
  output logic [1:0]  direction,
  output logic        moving
);

  localparam int AGE_W = $clog2(PENDING_FRAMES + 1);
  localparam logic signed [11:0] STEP  = 12'(SPEED);
  localparam logic signed [11:0] X_MAX = 12'(SCREEN_W - OBJECT_W);
  localparam logic signed [11:0] Y_MAX = 12'(SCREEN_H - OBJECT_H);

  state_t            state_q, state_nxt;
  dir_t              dir_q, dir_nxt;
  logic [10:0]       x_q, x_nxt, y_q, y_nxt;
  logic [3:0]        frame_hits;
  logic              pend_vld;
  dir_t              pend_dir;
  logic [AGE_W-1:0]  pend_age, age_inc;

  logic              pv_eff, consume, move_en, stop_req, clamp;
  dir_t              pd_eff, cur_dir, move_dir;
  logic signed [11:0] sx, sy;

  hit_edge_accumulator u_hits (
    .clk          (clk),
    .reset        (reset),
    .startOfFrame (startOfFrame),
    .collision    (collision),
    .HitEdgeCode  (HitEdgeCode),
    .frameHits    (frame_hits)
  );

  // A key arriving with startOfFrame takes part in that evaluation.
  assign pv_eff  = keyValid | pend_vld;
  assign pd_eff  = keyValid ? dir_t'(keyDir) : pend_dir;
  assign age_inc = (keyValid ? '0 : pend_age) + AGE_W'(1);

  always_comb begin
    state_nxt = state_q;
    dir_nxt   = dir_q;
    x_nxt     = x_q;
    y_nxt     = y_q;
    consume   = 1'b0;
    move_en   = 1'b0;
    stop_req  = 1'b0;
    clamp     = 1'b0;
    cur_dir   = dir_q;
    move_dir  = dir_q;
    sx        = $signed({1'b0, x_q});
    sy        = $signed({1'b0, y_q});

    unique case (state_q)
      ST_IDLE, ST_MOVING: begin
        if (state_q == ST_MOVING || pv_eff) begin
          if (pv_eff && !frame_hits[edge_idx(pd_eff)]) begin
            cur_dir = pd_eff;
            consume = 1'b1;
          end
          dir_nxt = cur_dir;
          move_en = 1'b1;
          if (frame_hits[edge_idx(cur_dir)]) begin
            move_dir = opposite(cur_dir);
            stop_req = 1'b1;
          end else begin
            move_dir = cur_dir;
          end
        end
      end
      ST_STOPPED: begin
        if (pv_eff && !frame_hits[edge_idx(pd_eff)]) begin
          dir_nxt  = pd_eff;
          consume  = 1'b1;
          move_dir = pd_eff;
          move_en  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    unique case (move_dir)
      UP:      sy = sy - STEP;
      DOWN:    sy = sy + STEP;
      LEFT:    sx = sx - STEP;
      default: sx = sx + STEP;
    endcase

    if (sy[11]) begin
      sy    = '0;
      clamp = 1'b1;
    end else if (sy > Y_MAX) begin
      sy    = Y_MAX;
      clamp = 1'b1;
    end

`ifdef PACMAN_TUNNEL_WRAP_EN
    if (sx[11]) begin
      sx = X_MAX;
    end else if (sx > X_MAX) begin
      sx = '0;
    end
`else
    if (sx[11]) begin
      sx    = '0;
      clamp = 1'b1;
    end else if (sx > X_MAX) begin
      sx    = X_MAX;
      clamp = 1'b1;
    end
`endif

    if (move_en) begin
      x_nxt     = sx[10:0];
      y_nxt     = sy[10:0];
      state_nxt = (stop_req || clamp) ? ST_STOPPED : ST_MOVING;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      dir_q   <= RIGHT;
      x_q     <= 11'(INITIAL_X);
      y_q     <= 11'(INITIAL_Y);
    end else if (startOfFrame) begin
      state_q <= state_nxt;
      dir_q   <= dir_nxt;
      x_q     <= x_nxt;
      y_q     <= y_nxt;
    end
  end

  // Each evaluated frame ages an unconsumed request; it expires after PENDING_FRAMES frames.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_vld <= 1'b0;
      pend_age <= '0;
      pend_dir <= UP;
    end else begin
      if (keyValid) begin
        pend_dir <= dir_t'(keyDir);
      end
      if (startOfFrame) begin
        if (consume || !pv_eff) begin
          pend_vld <= 1'b0;
          pend_age <= '0;
        end else if (age_inc == AGE_W'(PENDING_FRAMES)) begin
          pend_vld <= 1'b0;
          pend_age <= '0;
        end else begin
          pend_vld <= 1'b1;
          pend_age <= age_inc;
        end
      end else if (keyValid) begin
        pend_vld <= 1'b1;
        pend_age <= '0;
      end
    end
  end

  assign topLeftX  = x_q;
  assign topLeftY  = y_q;
  assign direction = dir_q;
  assign moving    = (state_q == ST_MOVING);

endmodule

// File: tb/tb_pacman_move_ctrl.sv
// Directed bench for pacman_move_ctrl; expected outputs are queued per frame and checked after it.
module tb_pacman_move_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        startOfFrame;
  logic        keyValid;
  logic [1:0]  keyDir;
  logic        collision;
  logic [3:0]  HitEdgeCode;
  logic [10:0] topLeftX;
  logic [10:0] topLeftY;
  logic [1:0]  direction;
  logic        moving;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic [1:0]  d;
    logic        m;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  pacman_move_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .startOfFrame (startOfFrame),
    .keyValid     (keyValid),
    .keyDir       (keyDir),
    .collision    (collision),
    .HitEdgeCode  (HitEdgeCode),
    .topLeftX     (topLeftX),
    .topLeftY     (topLeftY),
    .direction    (direction),
    .moving       (moving)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    vectors++;
    assert (topLeftX === e.x) else begin
      miscompares++;
      $error("FAIL %s topLeftX: observed %0d expected %0d", tag, topLeftX, e.x);
    end
    assert (topLeftY === e.y) else begin
      miscompares++;
      $error("FAIL %s topLeftY: observed %0d expected %0d", tag, topLeftY, e.y);
    end
    assert (direction === e.d) else begin
      miscompares++;
      $error("FAIL %s direction: observed %b expected %b", tag, direction, e.d);
    end
    assert (moving === e.m) else begin
      miscompares++;
      $error("FAIL %s moving: observed %b expected %b", tag, moving, e.m);
    end
  endtask

  task automatic expect_now(input int x, input int y, input logic [1:0] d,
                            input logic m, input string tag);
    sb.push_back('{x: 11'(x), y: 11'(y), d: d, m: m});
    check_out(tag);
  endtask

  task automatic frame(input int x, input int y, input logic [1:0] d, input logic m,
                       input string tag, input logic key, input logic [1:0] kd);
    sb.push_back('{x: 11'(x), y: 11'(y), d: d, m: m});
    keyValid     = key;
    keyDir       = kd;
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    keyValid     = 1'b0;
    check_out(tag);
  endtask

  task automatic gap(input logic coll, input logic [3:0] code);
    collision   = coll;
    HitEdgeCode = code;
    tick();
    tick();
    collision   = 1'b0;
    HitEdgeCode = 4'b0000;
  endtask

  task automatic press(input logic [1:0] kd);
    keyValid = 1'b1;
    keyDir   = kd;
    tick();
    keyValid = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    startOfFrame = 1'b0;
    keyValid     = 1'b0;
    keyDir       = 2'b00;
    collision    = 1'b0;
    HitEdgeCode  = 4'b0000;
    tick();
    tick();
    reset = 1'b0;
    expect_now(288, 224, 2'b11, 1'b0, "reset");
    gap(1'b0, 4'b0000);
    frame(288, 224, 2'b11, 1'b0, "idle_hold", 1'b0, 2'b00);

    press(2'b11);
    for (int i = 1; i <= 3; i++) begin
      gap(1'b0, 4'b0000);
      frame(288 + 2 * i, 224, 2'b11, 1'b1, "run_right", 1'b0, 2'b00);
    end

    gap(1'b1, 4'b0010);
    frame(292, 224, 2'b11, 1'b0, "pull_back", 1'b0, 2'b00);
    for (int i = 0; i < 2; i++) begin
      gap(1'b0, 4'b0000);
      frame(292, 224, 2'b11, 1'b0, "stopped_hold", 1'b0, 2'b00);
    end

    press(2'b11);
    gap(1'b0, 4'b0000);
    frame(294, 224, 2'b11, 1'b1, "restart", 1'b0, 2'b00);

    press(2'b00);
    for (int i = 1; i <= 4; i++) begin
      gap(1'b1, 4'b0100);
      frame(294 + 2 * i, 224, 2'b11, 1'b1, "turn_blocked", 1'b0, 2'b00);
    end
    gap(1'b0, 4'b0000);
    frame(302, 222, 2'b00, 1'b1, "turn_frame5", 1'b0, 2'b00);

    press(2'b11);
    gap(1'b0, 4'b0000);
    frame(304, 222, 2'b11, 1'b1, "turn_right", 1'b0, 2'b00);

    press(2'b00);
    for (int i = 1; i <= 8; i++) begin
      gap(1'b1, 4'b0100);
      frame(304 + 2 * i, 222, 2'b11, 1'b1, "expire_blocked", 1'b0, 2'b00);
    end
    for (int i = 1; i <= 2; i++) begin
      gap(1'b0, 4'b0000);
      frame(320 + 2 * i, 222, 2'b11, 1'b1, "expired", 1'b0, 2'b00);
    end

    press(2'b00);
    gap(1'b1, 4'b0010);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_now(288, 224, 2'b11, 1'b0, "mid_reset");
    gap(1'b0, 4'b0000);
    frame(288, 224, 2'b11, 1'b0, "post_reset_idle", 1'b0, 2'b00);

    gap(1'b0, 4'b0000);
    frame(286, 224, 2'b10, 1'b1, "key_with_sof", 1'b1, 2'b10);
    for (int k = 2; k <= 144; k++) begin
      gap(1'b0, 4'b0000);
      frame(288 - 2 * k, 224, 2'b10, 1'b1, "run_left", 1'b0, 2'b00);
    end
    gap(1'b0, 4'b0000);
`ifdef PACMAN_TUNNEL_WRAP_EN
    frame(608, 224, 2'b10, 1'b1, "left_edge_wrap", 1'b0, 2'b00);
`else
    frame(0, 224, 2'b10, 1'b0, "left_edge_clamp", 1'b0, 2'b00);
    gap(1'b0, 4'b0000);
    frame(0, 224, 2'b10, 1'b0, "left_edge_hold", 1'b0, 2'b00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pacman_move_ctrl.md
# pacman_move_ctrl

Frame-rate motion controller for the Pac-Man sprite. It consumes the renderer's per-pixel wall-collision and hit-edge code, plus key requests, and produces the sprite's top-left position and facing direction. These outputs feed back into the square-object and bitmap renderer. It is the producing end of the direction/offset interface and the consuming end of the hit-edge interface.

## Interface
- INITIAL_X, 288, top-left X after reset (pixels)
- INITIAL_Y, 224, top-left Y after reset (pixels)
- SPEED, 2, pixels moved per frame (1..8)
- PENDING_FRAMES, 8, frames a buffered turn request stays valid
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- startOfFrame  in  1  one-cycle pulse per video frame
- keyValid  in  1  one-cycle key-press strobe
- keyDir  in  2  requested direction: 00 up, 01 down, 10 left, 11 right
- collision  in  1  Pac-Man pixel overlaps wall pixel this cycle
- HitEdgeCode  in  4  {Left, Top, Right, Bottom} from renderer, valid with collision
- topLeftX  out  11  sprite X
- topLeftY  out  11  sprite Y
- direction  out  2  facing direction, same encoding as keyDir
- moving  out  1  high in MOVING state

## Operation
- Edge latch: each cycle with collision=1, OR HitEdgeCode into hitLatch. On startOfFrame, the evaluation uses the old latch, and the latch reloads with the current cycle's (collision ? HitEdgeCode : 0).
- Blocking edge per direction: up→Top (bit2), down→Bottom (bit0), left→Left (bit3), right→Right (bit1).
- Pending request: keyValid loads pendingDir, sets pendingValid, and clears pendingAge. A key and startOfFrame in the same cycle: the new key takes part in that evaluation.
- States and transitions, all evaluated only on startOfFrame:
  - IDLE (after reset): stays until pendingValid=1, then follows the MOVING rules.
  - MOVING:
    - If pendingValid=1 and the pendingDir edge is clear, adopt pendingDir and clear pendingValid.
    - Then, if the current-direction edge is set, pull back SPEED px opposite to direction and go to STOPPED. Otherwise step SPEED px along direction.
  - STOPPED: if pendingValid=1 and its edge is clear, adopt it, step, and go to MOVING. Otherwise hold position; no repeated pull-back.
- pendingAge increments each frame while pendingValid=1. When it reaches PENDING_FRAMES, pendingValid clears.
- Arithmetic: a 12-bit signed intermediate holds the new position, then range checks apply.
- Y range is 0..SCREEN_H−OBJECT_H. Out-of-range Y clamps to the limit and forces STOPPED.
- X range is 0..SCREEN_W−OBJECT_W (see Configuration).

## Timing
- All outputs are registered. An evaluation on startOfFrame at cycle N is visible at cycle N+1 and held for the rest of the frame.
- Reset values: topLeftX=INITIAL_X, topLeftY=INITIAL_Y, direction=11 (right), moving=0, state IDLE. Internally: hitLatch=0, pendingValid=0, pendingAge=0.
- Reset asserted mid-frame discards the latch and the pending request. Reset and startOfFrame in the same cycle: reset wins.
- Consecutive startOfFrame pulses one cycle apart are legal. Each pulse is a full evaluation.

## Configuration
- PACMAN_TUNNEL_WRAP_EN defined: horizontal tunnel.
  - X < 0 wraps to SCREEN_W−OBJECT_W.
  - X > SCREEN_W−OBJECT_W wraps to 0.
  - The state stays MOVING.
- Undefined: X clamps to 0 or SCREEN_W−OBJECT_W and the state goes to STOPPED.

## Structure
- Shared package pacman_pkg holds:
  - dir_t enum: UP=0, DOWN=1, LEFT=2, RIGHT=3
  - edge bit indices: EDGE_LEFT=3, EDGE_TOP=2, EDGE_RIGHT=1, EDGE_BOTTOM=0
  - OBJECT_W=32, OBJECT_H=32, SCREEN_W=640, SCREEN_H=480
  - state enum
- Sub-module hit_edge_accumulator: the per-frame OR-latch with reload on startOfFrame. It outputs frameHits[3:0].

## Test plan
- Reset, then keyValid keyDir=11, then 3 frames with no collision: topLeftX goes 288→290→292→294, Y=224, moving=1, direction=11.
- Moving right, collision with HitEdgeCode=0010 during a frame: at the next startOfFrame, X pulls back by 2, state is STOPPED and moving=0. Later frames hold X.
- Moving right, key up (00) while Top is blocked every frame: direction stays 11. Top clears on frame 5: turn to 00 and Y decreases by 2. With Top blocked 9 frames, the request expires and direction stays 11.
- keyValid and startOfFrame in the same cycle, keyDir=10, no hits: that same frame, direction=10 and X decreases by 2.
- X=2 moving left, SPEED=2, two frames: with PACMAN_TUNNEL_WRAP_EN, X goes 0 then 608 (SCREEN_W−OBJECT_W−2=606? no: −2 wraps to 608) and moving=1. Without the macro, X goes 0 then stays 0 with STOPPED.
- Reset asserted mid-frame after a collision: outputs return to 288/224/11/0, and the next startOfFrame without a key leaves the state IDLE.
